seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed 7-segment scanner fed by the binary-to-BCD converter.
//  Latches a packed BCD word when the converter's done rises and drives one digit per scan slot.
//  Inserts an all-off guard interval between slots to suppress ghosting.
//  Sits between the converter and the board's segment/anode pins.
// PARAMETERS
//  DIGITS     2      number of BCD digits / anodes (>=1)
//  SCAN_DIV   50000  clk cycles per digit DRIVE slot (>=2)
//  BLANK_CYC  16     clk cycles of all-anodes-off guard before each slot (>=1)
// PORTS
//  clk        in   1          single clock, all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  bcd        in   4*DIGITS   packed BCD, digit 0 = bcd[3:0] = least significant
//  bcd_valid  in   1          converter done level; rising edge loads bcd
//  seg        out  7          {g,f,e,d,c,b,a}, active-low
//  an         out  DIGITS     anode enables, active-low, at most one low; an[i] = digit i
//  frame      out  1          1-cycle pulse when digit index wraps DIGITS-1 -> 0
// BEHAVIOUR
//  Reset: shadow=0, valid_d=0, idx=0, cnt=0, state=BLANK, an=all 1, seg=7'h7F, frame=0.
//  Load: a cycle with bcd_valid=1 and valid_d=0 writes shadow<=bcd on that edge.
//   Level-high bcd_valid does not reload; valid_d samples bcd_valid each cycle.
//  FSM BLANK: an=all 1, seg=7'h7F; after BLANK_CYC cycles -> DRIVE, cnt cleared.
//   The same edge captures cur=shadow[4*idx+3 -: 4] (pre-edge shadow value).
//  FSM DRIVE: an[idx]=0 and seg=decode(cur) for SCAN_DIV cycles.
//   Then idx <= (idx==DIGITS-1) ? 0 : idx+1 and state -> BLANK.
//   frame=1 in the cycle leaving DRIVE with idx==DIGITS-1.
//  Slot period = BLANK_CYC+SCAN_DIV cycles; frame period = DIGITS times that.
//  Outputs are registered: one cycle of latency from the state change to the pins.
//  A load during DRIVE never alters the current slot; the new value shows from the next slot capture.
//  Load on the same edge as DRIVE entry: the slot shows the old shadow digit.
//  Decode: 0-9 standard glyphs. 10-15 (invalid BCD) show '-' (seg=7'h3F, g only).
//  cnt width = $clog2(max(SCAN_DIV,BLANK_CYC)); idx width = max(1,$clog2(DIGITS)); both wrap explicitly, never by overflow.
//  rst asserted mid-slot: reset values on the next edge; scanning restarts at idx 0 in BLANK.
//  DIGITS=1: idx stays 0; frame pulses every slot.
// CONFIGURATION
//  SEG_BLANK_EN defined: leading-zero blanking.
//   Digit i>0 is suppressed (an stays all 1 for its DRIVE slot, timing unchanged)
//   when digits i..DIGITS-1 of the captured shadow are all 0. Digit 0 is always shown.
//  SEG_BLANK_EN undefined: every digit is shown, including leading zeros.
// STRUCTURE
//  Package seg_disp_pkg:
//   SEG_OFF=7'h7F, SEG_DASH=7'h3F, the 10-entry glyph constants,
//   state enum {ST_BLANK, ST_DRIVE}, function bcd_to_seg(4-bit)->7-bit.
//  One combinational sub-module seg_decode (4-bit digit -> 7-bit active-low);
//   top holds the FSM, counters, shadow register and output registers.
// TESTING  (DIGITS=2, SCAN_DIV=4, BLANK_CYC=2 unless noted)
//  1 rst for 2 cycles -> an=2'b11, seg=7'h7F, frame=0; first DRIVE (an=2'b10) 3 cycles after rst drops.
//  2 bcd=8'h42, pulse bcd_valid -> slot0 an=2'b10 seg=7'h24; slot1 an=2'b01 seg=7'h19.
//  3 Timing -> each slot shows an=11 for 2 cycles then driven for 4; frame pulses every 12 cycles.
//  4 bcd=8'h05 -> with SEG_BLANK_EN: slot1 an=2'b11, slot0 seg=7'h12;
//     without: slot1 an=2'b01 seg=7'h40.
//  5 bcd=8'hA3 -> slot1 seg=7'h3F (dash), slot0 seg=7'h30; bcd_valid held high -> no reload on later changes.
//  6 Load 8'h99 mid-DRIVE of slot0 -> slot0 keeps old glyph, slot1 shows 7'h10;
//     rst mid-DRIVE -> reset values next edge.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared constants, state type and BCD glyph table for the segment scanner.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_disp_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Combinational BCD digit to active-low 7-segment glyph.
// Codes 10-15 render as a dash.
module seg_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = bcd_to_seg(i_digit);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner with an all-off guard before each slot.
// Optional leading-zero blanking when SEG_BLANK_EN is defined.
module seg_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  bcd_valid,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int unsigned MAXC =
    (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CW = $clog2(MAXC);
  localparam int unsigned IW =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] r_shadow;
  logic                r_valid_d;
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  state_t              r_state;
  logic [3:0]          r_cur;
  logic                r_sup;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic                r_frame;

  state_t              w_state_n;
  logic [CW-1:0]       w_cnt_n;
  logic [IW-1:0]       w_idx_n;
  logic                w_cap;
  logic                w_last;
  logic [DIGITS-1:0]   w_an_n;
  logic [6:0]          w_seg_n;
  logic                w_frame_n;
  logic [6:0]          w_seg;
  logic                w_sup_n;

  seg_decode u_dec (
    .i_digit (r_cur),
    .o_seg   (w_seg)
  );

`ifdef SEG_BLANK_EN
  // Suppress digit idx>0 when it and every more significant digit are zero.
  always_comb begin
    w_sup_n = (r_idx != '0);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i >= int'(r_idx) && r_shadow[4*i +: 4] != 4'd0)
        w_sup_n = 1'b0;
    end
  end
`else
  assign w_sup_n = 1'b0;
`endif

  assign w_last = (r_idx == IW'(DIGITS-1));

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_idx_n   = r_idx;
    w_cap     = 1'b0;
    w_frame_n = 1'b0;
    w_an_n    = '1;
    w_seg_n   = SEG_OFF;
    unique case (r_state)
      ST_BLANK: begin
        if (r_cnt == CW'(BLANK_CYC-1)) begin
          w_state_n = ST_DRIVE;
          w_cnt_n   = '0;
          w_cap     = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!r_sup) begin
          w_an_n  = ~(DIGITS'(1) << r_idx);
          w_seg_n = w_seg;
        end
        if (r_cnt == CW'(SCAN_DIV-1)) begin
          w_state_n = ST_BLANK;
          w_cnt_n   = '0;
          w_idx_n   = w_last ? '0 : r_idx + 1'b1;
          w_frame_n = w_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_valid_d <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_state   <= ST_BLANK;
      r_cur     <= 4'd0;
      r_sup     <= 1'b0;
      r_an      <= '1;
      r_seg     <= SEG_OFF;
      r_frame   <= 1'b0;
    end else begin
      r_valid_d <= bcd_valid;
      if (bcd_valid && !r_valid_d)
        r_shadow <= bcd;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      // Capture uses the pre-edge shadow, so a same-edge load waits a slot.
      if (w_cap) begin
        r_cur <= r_shadow[4*r_idx +: 4];
        r_sup <= w_sup_n;
      end
      r_an    <= w_an_n;
      r_seg   <= w_seg_n;
      r_frame <= w_frame_n;
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign frame = r_frame;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=2, SCAN_DIV=4, BLANK_CYC=2).
// Define SEG_BLANK_EN to match a leading-zero-blanking build.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bcd = 8'h00;
  logic       bcd_valid = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  logic [8:0] q[$];
  logic [8:0] exp_v;

  seg_scan_driver #(
    .DIGITS    (2),
    .SCAN_DIV  (4),
    .BLANK_CYC (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .seg       (seg),
    .an        (an),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  // Edges since reset release; slot k pins are driven after edges 3+6k..6+6k.
  always @(posedge clk) begin
    if (rst) ecnt = 0;
    else     ecnt = ecnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic at_e(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bcd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (an !== 2'b11) begin
      errors++;
      $display("FAIL rst_an got %b want 11", an);
    end
    checks++;
    if (seg !== 7'h7F) begin
      errors++;
      $display("FAIL rst_seg got %h want 7f", seg);
    end
    checks++;
    if (frame !== 1'b0) begin
      errors++;
      $display("FAIL rst_frame got %b want 0", frame);
    end
    at_e(2);
    checks++;
    if (an !== 2'b11) begin
      errors++;
      $display("FAIL first_blank an got %b want 11", an);
    end
    at_e(3);
    checks++;
    if (an !== 2'b10 || seg !== 7'h40) begin
      errors++;
      $display("FAIL first_drive got %b/%h want 10/40", an, seg);
    end
  endtask

  task automatic test_load_basic();
    do_reset();
    bcd = 8'h42;
    bcd_valid = 1'b1;
    q.push_back({2'b10, 7'h24});
    q.push_back({2'b01, 7'h19});
    at_e(1);
    bcd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      at_e(4 + 6*k);
      exp_v = q.pop_front();
      checks++;
      if ({an, seg} !== exp_v) begin
        errors++;
        $display("FAIL load_slot%0d got %b/%h want %b/%h",
                 k, an, seg, exp_v[8:7], exp_v[6:0]);
      end
    end
  endtask

  task automatic test_timing();
    logic [1:0] ea;
    logic       ef;
    int         s;
    do_reset();
    bcd = 8'h42;
    bcd_valid = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      at_e(e);
      if (e == 1) bcd_valid = 1'b0;
      s  = (e - 1) / 6;
      ea = (((e - 1) % 6) < 2) ? 2'b11 :
           ((s % 2) == 1) ? 2'b01 : 2'b10;
      ef = ((e % 12) == 0);
      checks++;
      if (an !== ea) begin
        errors++;
        $display("FAIL timing_an e%0d got %b want %b", e, an, ea);
      end
      checks++;
      if (frame !== ef) begin
        errors++;
        $display("FAIL timing_frame e%0d got %b want %b",
                 e, frame, ef);
      end
    end
  endtask

  task automatic test_leading_zero();
    do_reset();
    bcd = 8'h05;
    bcd_valid = 1'b1;
    q.push_back({2'b10, 7'h12});
`ifdef SEG_BLANK_EN
    q.push_back({2'b11, 7'h7F});
`else
    q.push_back({2'b01, 7'h40});
`endif
    at_e(1);
    bcd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      at_e(4 + 6*k);
      exp_v = q.pop_front();
      checks++;
      if ({an, seg} !== exp_v) begin
        errors++;
        $display("FAIL lzb_slot%0d got %b/%h want %b/%h",
                 k, an, seg, exp_v[8:7], exp_v[6:0]);
      end
    end
  endtask

  task automatic test_dash_hold();
    do_reset();
    bcd = 8'hA3;
    bcd_valid = 1'b1;
    q.push_back({2'b10, 7'h30});
    q.push_back({2'b01, 7'h3F});
    q.push_back({2'b10, 7'h30});
    q.push_back({2'b01, 7'h3F});
    at_e(3);
    bcd = 8'h42;
    for (int k = 0; k < 4; k++) begin
      at_e(4 + 6*k);
      exp_v = q.pop_front();
      checks++;
      if ({an, seg} !== exp_v) begin
        errors++;
        $display("FAIL hold_slot%0d got %b/%h want %b/%h",
                 k, an, seg, exp_v[8:7], exp_v[6:0]);
      end
    end
    bcd_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bcd = 8'h42;
    bcd_valid = 1'b1;
    q.push_back({2'b10, 7'h24});
    q.push_back({2'b01, 7'h10});
    q.push_back({2'b10, 7'h10});
    q.push_back({2'b01, 7'h79});
    at_e(1);
    bcd_valid = 1'b0;
    at_e(3);
    bcd = 8'h99;
    bcd_valid = 1'b1;
    at_e(5);
    exp_v = q.pop_front();
    checks++;
    if ({an, seg} !== exp_v) begin
      errors++;
      $display("FAIL midload_slot0 got %b/%h want %b/%h",
               an, seg, exp_v[8:7], exp_v[6:0]);
    end
    at_e(6);
    bcd_valid = 1'b0;
    at_e(10);
    exp_v = q.pop_front();
    checks++;
    if ({an, seg} !== exp_v) begin
      errors++;
      $display("FAIL midload_slot1 got %b/%h want %b/%h",
               an, seg, exp_v[8:7], exp_v[6:0]);
    end
    at_e(13);
    bcd = 8'h17;
    bcd_valid = 1'b1;
    for (int k = 2; k < 4; k++) begin
      at_e(4 + 6*k);
      exp_v = q.pop_front();
      checks++;
      if ({an, seg} !== exp_v) begin
        errors++;
        $display("FAIL sameedge_slot%0d got %b/%h want %b/%h",
                 k, an, seg, exp_v[8:7], exp_v[6:0]);
      end
    end
    at_e(21);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 2'b11 || seg !== 7'h7F || frame !== 1'b0) begin
      errors++;
      $display("FAIL midrst got %b/%h/%b want 11/7f/0",
               an, seg, frame);
    end
    rst = 1'b0;
    bcd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_timing();
    test_leading_zero();
    test_dash_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
